// File: rtl/bg_layer_mixer.sv
// N-layer background compositor: picks the frontmost opaque layer using a vblank-committed priority order.
// Optional solo-layer debug register enabled by defining BG_LAYER_MIXER_SOLO_EN.

module bg_layer_mixer_lane #(
    parameter int COL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             en,
    input  logic [3:0]       pix_bit,
    input  logic [COL_W-1:0] pix_col,
    input  logic             cp15,
    input  logic             cp8,
    output logic [3:0]       bit_q,
    output logic [COL_W-1:0] col_q,
    output logic             opq_q,
    output logic             pri_q
);
    logic [3:0]       bit_d;
    logic [COL_W-1:0] col_d;
    logic             opq_d;
    logic             pri_d;

    always_comb begin
        bit_d = bit_q;
        col_d = col_q;
        opq_d = opq_q;
        pri_d = pri_q;
        if (ce) begin
            bit_d = pix_bit;
            col_d = pix_col;
            opq_d = en & (|pix_bit);
            // CP8 only needs the upper colour half, not full opacity
            pri_d = (cp15 & en & (|pix_bit)) | (cp8 & pix_bit[3] & en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= '0;
            col_q <= '0;
            opq_q <= 1'b0;
            pri_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
            col_q <= col_d;
            opq_q <= opq_d;
            pri_q <= pri_d;
        end
    end
endmodule

module bg_layer_mixer #(
    parameter int          NUM_LAYERS = 3,
    parameter int          COL_W      = 4,
    parameter int          LAYER_W    = 3,
    parameter logic [7:0]  PRIO_ADDR  = 8'h98
) (
    input  logic                          CLK_32M,
    input  logic                          RESET_N,
    input  logic                          CE_PIX,
    input  logic [7:0]                    IO_A,
    input  logic [7:0]                    IO_DIN,
    input  logic                          IOWR,
    input  logic                          VBLANK,
    input  logic [NUM_LAYERS-1:0]         LAYER_EN,
    input  logic [4*NUM_LAYERS-1:0]       PIX_BIT,
    input  logic [COL_W*NUM_LAYERS-1:0]   PIX_COL,
    input  logic [NUM_LAYERS-1:0]         PIX_CP15,
    input  logic [NUM_LAYERS-1:0]         PIX_CP8,
    output logic [LAYER_W+COL_W+3:0]      PAL_IDX,
    output logic [LAYER_W-1:0]            OUT_LAYER,
    output logic                          OUT_OPAQUE,
    output logic                          P1L
);
    localparam int PAL_W = LAYER_W + COL_W + 4;

    logic [NUM_LAYERS-1:0][LAYER_W-1:0] pend_q, pend_d;
    logic [NUM_LAYERS-1:0][LAYER_W-1:0] act_q, act_d;
    logic                               vblank_q;
    logic                               vb_rise;

    logic [NUM_LAYERS-1:0][3:0]         bit_s1;
    logic [NUM_LAYERS-1:0][COL_W-1:0]   col_s1;
    logic [NUM_LAYERS-1:0]              opq_s1, pri_s1;
    logic [NUM_LAYERS-1:0]              solo_mask;
    logic [NUM_LAYERS-1:0]              opq_m;
    logic [NUM_LAYERS-1:0]              slot_opq;

    logic [PAL_W-1:0]   pal_idx_q, pal_idx_d;
    logic [LAYER_W-1:0] out_layer_q, out_layer_d;
    logic               out_opaque_q, out_opaque_d;
    logic               p1l_q, p1l_d;

    logic               found, any_vld;
    logic [LAYER_W-1:0] win_id, last_id, sel_id;
    logic [COL_W-1:0]   sel_col;
    logic [3:0]         sel_bit;

    logic unused_io;
    assign unused_io = &{1'b0, IO_DIN[7:LAYER_W]};

    assign vb_rise = VBLANK & ~vblank_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_lane
            bg_layer_mixer_lane #(.COL_W(COL_W)) u_lane (
                .clk     (CLK_32M),
                .rst_n   (RESET_N),
                .ce      (CE_PIX),
                .en      (LAYER_EN[gi]),
                .pix_bit (PIX_BIT[4*gi +: 4]),
                .pix_col (PIX_COL[COL_W*gi +: COL_W]),
                .cp15    (PIX_CP15[gi]),
                .cp8     (PIX_CP8[gi]),
                .bit_q   (bit_s1[gi]),
                .col_q   (col_s1[gi]),
                .opq_q   (opq_s1[gi]),
                .pri_q   (pri_s1[gi])
            );
        end
    endgenerate

    // Active order latches the pre-write pending value, so a write on the edge cycle waits a frame
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (vb_rise) act_d = pend_q;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (IOWR && IO_A == 8'(int'(PRIO_ADDR) + k)) pend_d[k] = IO_DIN[LAYER_W-1:0];
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                pend_q[k] <= LAYER_W'(k);
                act_q[k]  <= LAYER_W'(k);
            end
            vblank_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            act_q    <= act_d;
            vblank_q <= VBLANK;
        end
    end

`ifdef BG_LAYER_MIXER_SOLO_EN
    logic               solo_en_q, solo_en_d;
    logic [LAYER_W-1:0] solo_id_q, solo_id_d;

    always_comb begin
        solo_en_d = solo_en_q;
        solo_id_d = solo_id_q;
        if (IOWR && IO_A == 8'(int'(PRIO_ADDR) + NUM_LAYERS)) begin
            solo_en_d = IO_DIN[7];
            solo_id_d = IO_DIN[LAYER_W-1:0];
        end
        for (int j = 0; j < NUM_LAYERS; j++)
            solo_mask[j] = ~solo_en_q | (solo_id_q == LAYER_W'(j));
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            solo_en_q <= 1'b0;
            solo_id_q <= '0;
        end else begin
            solo_en_q <= solo_en_d;
            solo_id_q <= solo_id_d;
        end
    end
`else
    assign solo_mask = '1;
`endif

    assign opq_m = opq_s1 & solo_mask;

    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            slot_opq[k] = 1'b0;
            for (int j = 0; j < NUM_LAYERS; j++)
                if (act_q[k] == LAYER_W'(j) && opq_m[j]) slot_opq[k] = 1'b1;
        end
    end

    // Priority scan: earliest valid opaque slot wins, else fall back to the last valid slot
    always_comb begin
        found   = 1'b0;
        any_vld = 1'b0;
        win_id  = '0;
        last_id = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (int'(act_q[k]) < NUM_LAYERS) begin
                any_vld = 1'b1;
                last_id = act_q[k];
                if (!found && slot_opq[k]) begin
                    found  = 1'b1;
                    win_id = act_q[k];
                end
            end
        end
        sel_id  = found ? win_id : last_id;
        sel_col = '0;
        sel_bit = '0;
        for (int j = 0; j < NUM_LAYERS; j++) begin
            if (sel_id == LAYER_W'(j)) begin
                sel_col = col_s1[j];
                sel_bit = bit_s1[j];
            end
        end

        pal_idx_d    = pal_idx_q;
        out_layer_d  = out_layer_q;
        out_opaque_d = out_opaque_q;
        p1l_d        = p1l_q;
        if (CE_PIX) begin
            pal_idx_d    = any_vld ? {sel_id, sel_col, (found ? sel_bit : 4'd0)} : '0;
            out_layer_d  = any_vld ? sel_id : '0;
            out_opaque_d = found;
            p1l_d        = ~|(pri_s1 & solo_mask);
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            pal_idx_q    <= '0;
            out_layer_q  <= '0;
            out_opaque_q <= 1'b0;
            p1l_q        <= 1'b1;
        end else begin
            pal_idx_q    <= pal_idx_d;
            out_layer_q  <= out_layer_d;
            out_opaque_q <= out_opaque_d;
            p1l_q        <= p1l_d;
        end
    end

    assign PAL_IDX    = pal_idx_q;
    assign OUT_LAYER  = out_layer_q;
    assign OUT_OPAQUE = out_opaque_q;
    assign P1L        = p1l_q;
endmodule

// File: tb/tb_bg_layer_mixer.sv
// Directed bench for bg_layer_mixer (3 layers, COL_W=4, LAYER_W=3); expected values worked out by hand.
module tb_bg_layer_mixer;
    localparam int NL = 3;

    logic        CLK_32M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CE_PIX  = 1'b0;
    logic [7:0]  IO_A    = '0;
    logic [7:0]  IO_DIN  = '0;
    logic        IOWR    = 1'b0;
    logic        VBLANK  = 1'b0;
    logic [NL-1:0]   LAYER_EN = '1;
    logic [4*NL-1:0] PIX_BIT  = '0;
    logic [4*NL-1:0] PIX_COL  = '0;
    logic [NL-1:0]   PIX_CP15 = '0;
    logic [NL-1:0]   PIX_CP8  = '0;
    logic [10:0] PAL_IDX;
    logic [2:0]  OUT_LAYER;
    logic        OUT_OPAQUE;
    logic        P1L;

    int n_chk = 0;
    int n_err = 0;

    bg_layer_mixer #(.NUM_LAYERS(NL), .COL_W(4), .LAYER_W(3), .PRIO_ADDR(8'h98)) dut (
        .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX),
        .IO_A(IO_A), .IO_DIN(IO_DIN), .IOWR(IOWR), .VBLANK(VBLANK),
        .LAYER_EN(LAYER_EN), .PIX_BIT(PIX_BIT), .PIX_COL(PIX_COL),
        .PIX_CP15(PIX_CP15), .PIX_CP8(PIX_CP8),
        .PAL_IDX(PAL_IDX), .OUT_LAYER(OUT_LAYER), .OUT_OPAQUE(OUT_OPAQUE), .P1L(P1L)
    );

    always #5 CLK_32M = ~CLK_32M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one CE_PIX pulse every 4th clock
    task automatic tick();
        repeat (3) @(negedge CLK_32M);
        CE_PIX = 1'b1;
        @(negedge CLK_32M);
        CE_PIX = 1'b0;
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK_32M);
        IOWR = 1'b1; IO_A = a; IO_DIN = d;
        @(negedge CLK_32M);
        IOWR = 1'b0;
    endtask

    task automatic vb_pulse();
        @(negedge CLK_32M);
        VBLANK = 1'b1;
        repeat (2) @(negedge CLK_32M);
        VBLANK = 1'b0;
        @(negedge CLK_32M);
    endtask

    initial begin
        repeat (3) @(negedge CLK_32M);
        chk("rst_pal", 32'(PAL_IDX), 32'h0);
        chk("rst_layer", 32'(OUT_LAYER), 32'd0);
        chk("rst_opq", 32'(OUT_OPAQUE), 32'd0);
        chk("rst_p1l", 32'(P1L), 32'd1);
        RESET_N = 1'b1;

        // layer0 opaque in front
        PIX_BIT = {4'd0, 4'd3, 4'd5};
        PIX_COL = {4'd0, 4'd0, 4'd2};
        tick();
        chk("lat1_opq", 32'(OUT_OPAQUE), 32'd0);
        tick();
        chk("l0_pal", 32'(PAL_IDX), 32'h025);
        chk("l0_opq", 32'(OUT_OPAQUE), 32'd1);

        // only layer1 opaque
        PIX_BIT = {4'd0, 4'd7, 4'd0};
        PIX_COL = {4'd0, 4'd1, 4'd2};
        tick(); tick();
        chk("l1_layer", 32'(OUT_LAYER), 32'd1);
        chk("l1_pal", 32'(PAL_IDX), 32'h117);

        // nothing opaque: last slot's layer, BIT forced 0
        PIX_BIT = '0;
        PIX_COL = {4'd3, 4'd1, 4'd2};
        tick(); tick();
        chk("none_opq", 32'(OUT_OPAQUE), 32'd0);
        chk("none_layer", 32'(OUT_LAYER), 32'd2);
        chk("none_pal", 32'(PAL_IDX), 32'h230);

        // reorder mid-frame: must not apply before vblank
        PIX_BIT = {4'd4, 4'd0, 4'd6};
        PIX_COL = {4'd3, 4'd0, 4'd0};
        io_wr(8'h98, 8'd2);
        io_wr(8'h9A, 8'd0);
        tick(); tick();
        chk("mid_pal", 32'(PAL_IDX), 32'h006);
        vb_pulse();
        tick(); tick();
        chk("vb_layer", 32'(OUT_LAYER), 32'd2);
        chk("vb_pal", 32'(PAL_IDX), 32'h234);

        // P1L from CP15 and CP8 (order now 2,1,0)
        PIX_BIT = {4'd0, 4'd1, 4'd0};
        PIX_COL = '0;
        PIX_CP15 = 3'b010;
        tick(); tick();
        chk("cp15_p1l", 32'(P1L), 32'd0);
        chk("cp15_layer", 32'(OUT_LAYER), 32'd1);
        PIX_CP15 = '0;
        PIX_CP8 = 3'b001;
        PIX_BIT = {4'd0, 4'd0, 4'd8};
        LAYER_EN = 3'b110;
        tick(); tick();
        chk("cp8_dis_p1l", 32'(P1L), 32'd1);
        chk("cp8_dis_opq", 32'(OUT_OPAQUE), 32'd0);
        LAYER_EN = 3'b111;
        tick(); tick();
        chk("cp8_en_p1l", 32'(P1L), 32'd0);
        chk("cp8_en_pal", 32'(PAL_IDX), 32'h008);
        PIX_CP8 = '0;

        // write to slot1 on the vblank edge cycle
        PIX_BIT = {4'd0, 4'd2, 4'd1};
        @(negedge CLK_32M);
        IOWR = 1'b1; IO_A = 8'h99; IO_DIN = 8'd0; VBLANK = 1'b1;
        @(negedge CLK_32M);
        IOWR = 1'b0;
        @(negedge CLK_32M);
        VBLANK = 1'b0;
        tick(); tick();
        chk("edge_old", 32'(OUT_LAYER), 32'd1);
        vb_pulse();
        tick(); tick();
        chk("edge_new", 32'(OUT_LAYER), 32'd0);

        // asynchronous reset mid-line
        PIX_BIT = {4'd1, 4'd2, 4'd0};
        PIX_COL = '0;
        tick(); tick();
        chk("pre_rst_layer", 32'(OUT_LAYER), 32'd2);
        @(negedge CLK_32M);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_pal", 32'(PAL_IDX), 32'h0);
        chk("arst_opq", 32'(OUT_OPAQUE), 32'd0);
        chk("arst_p1l", 32'(P1L), 32'd1);
        @(negedge CLK_32M);
        RESET_N = 1'b1;
        tick(); tick();
        chk("ident_layer", 32'(OUT_LAYER), 32'd1);
        chk("ident_pal", 32'(PAL_IDX), 32'h102);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/bg_layer_mixer.md
Name: bg_layer_mixer

Overview:
- Parametrised N-layer background compositor; successor to the fixed two-layer A/B select on the B-D board.
- Takes per-layer pixel data (BIT, COL, CP15, CP8) from N layer engines, resolves the frontmost opaque layer using a programmable priority order, and emits a palette index, layer id and P1L to the palette chip and sprite mixer.
- Priority order is CPU-programmable over the IO bus and double-buffered so it only changes at vertical blank.

Parameters:
NUM_LAYERS, 3, number of layer inputs (2..8)
COL_W, 4, colour-bank bits per layer pixel
LAYER_W, 3, layer-id width; must satisfy 2**LAYER_W >= NUM_LAYERS
PRIO_ADDR, 8'h98, IO base address of priority slots; slot k is at PRIO_ADDR+k

Ports:
CLK_32M  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
CE_PIX  in  1  pixel clock enable
IO_A  in  8  IO address
IO_DIN  in  8  IO write data
IOWR  in  1  IO write strobe, one CLK_32M cycle
VBLANK  in  1  vertical blank level
LAYER_EN  in  NUM_LAYERS  per-layer debug enable
PIX_BIT  in  4*NUM_LAYERS  pixel bits; layer i at [4i+3:4i]
PIX_COL  in  COL_W*NUM_LAYERS  colour bank per layer
PIX_CP15  in  NUM_LAYERS  whole-pixel priority flag
PIX_CP8  in  NUM_LAYERS  upper-half-colour priority flag
PAL_IDX  out  LAYER_W+COL_W+4  {layer id, COL, BIT} of the winning layer
OUT_LAYER  out  LAYER_W  winning layer id
OUT_OPAQUE  out  1  winning pixel is non-zero
P1L  out  1  active-low "background over sprites" flag

Behaviour:
- Reset (async assert, sync release): PAL_IDX=0, OUT_LAYER=0, OUT_OPAQUE=0, P1L=1. Both pending and active order registers reset to identity: slot k = layer k, so slot 0 is frontmost and holds layer 0.
- IO write: when IOWR and IO_A == PRIO_ADDR+k (k < NUM_LAYERS), pending slot k <= IO_DIN[LAYER_W-1:0]. Writes to other addresses are ignored. Writes are independent of CE_PIX.
- Order commit: on the VBLANK rising edge (VBLANK sampled each CLK_32M), active <= pending. If an IO write coincides with the edge cycle, active takes the old pending value and the new write lands in pending only.
- Stage 1 (on CE_PIX): register the inputs.
  - opaque_i = LAYER_EN[i] & (BIT_i != 0).
  - pri_i = (PIX_CP15[i] & opaque_i) | (PIX_CP8[i] & BIT_i[3] & LAYER_EN[i]).
- Stage 2 (on CE_PIX): scan slots 0..NUM_LAYERS-1 and pick the first slot whose layer id is < NUM_LAYERS and opaque.
  - Output that layer's {id, COL, BIT} and set OUT_OPAQUE=1.
  - P1L = ~|pri.
- No opaque layer: use the last valid slot's layer, with BIT forced to 0 and OUT_OPAQUE=0. If no slot is valid, output all zeros.
- Duplicate ids in the order: the earliest slot wins. Layers absent from the order are never selected but still contribute to P1L.
- Latency: exactly 2 CE_PIX edges from input to output. Outputs hold between CE_PIX pulses.
- Order changes never take effect mid-frame.

Optional Feature:
- Macro: BG_LAYER_MIXER_SOLO_EN.
- When defined: extra IO register at PRIO_ADDR+NUM_LAYERS.
  - bit 7 = solo enable; bits [LAYER_W-1:0] = solo layer.
  - While solo is enabled, every layer except the solo layer is treated as transparent for selection and for P1L. The register takes effect immediately, not at vblank.
  - Reset value is 0.
- When undefined: that address is ignored and no solo logic exists.

Test Plan:
- Reset, then layer0 BIT=5/COL=2 and layer1 BIT=3, CE_PIX every 4th cycle -> after 2 CE_PIX: PAL_IDX={0,2,5}, OUT_OPAQUE=1.
- Layer0 BIT=0, layer1 BIT=7/COL=1, layer2 BIT=0 -> OUT_LAYER=1, PAL_IDX={1,1,7}. Then all BIT=0 -> OUT_OPAQUE=0, PAL_IDX low 4 bits = 0, OUT_LAYER=2.
- Write slot0=2, slot2=0 mid-frame -> output unchanged until the VBLANK rise; after it, layer2 with BIT=4 beats opaque layer0.
- Layer1 CP15=1 with BIT=1 -> P1L=0. Layer0 CP8=1 with BIT=8 and LAYER_EN[0]=0 -> P1L=1.
- IO write to slot1 in the same cycle as the VBLANK rise -> the new order applies only at the next VBLANK rise.
- Assert RESET_N low mid-line -> outputs clear immediately; the order returns to identity.
